// File: rtl/lc3_bus_pkg.sv
// Shared LC-3 bus definitions: word width, bus source indices and a constant log2 helper.
package lc3_bus_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    SRC_PC     = 2'd0,
    SRC_MARMUX = 2'd1,
    SRC_ALU    = 2'd2,
    SRC_MDR    = 2'd3
  } bus_src_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  int unsigned cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      // Wrap by subtraction so indices >= N are never formed for non-power-of-2 N.
      cand = 32'(last) + i;
      if (cand >= N) cand = cand - N;
      if (!gnt_valid && req[cand[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_mux_arb.sv
// Many-to-one bus mux: round-robin arbitration of valid/ready sources into a tagged output register.
module bus_mux_arb
  import lc3_bus_pkg::*;
#(
  parameter int unsigned INSIZE   = 2,
  parameter int unsigned SELSIZE  = 1,
  parameter int unsigned DATASIZE = WORD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATASIZE*INSIZE-1:0]   in,
  input  logic [INSIZE-1:0]            in_valid,
  output logic [INSIZE-1:0]            in_ready,
  output logic [DATASIZE-1:0]          out,
  output logic                         out_valid,
  output logic [SELSIZE-1:0]           out_src,
  input  logic                         out_ready
);

  logic [DATASIZE-1:0] out_q,   out_d;
  logic                valid_q, valid_d;
  logic [SELSIZE-1:0]  src_q,   src_d;
  logic [SELSIZE-1:0]  last_q,  last_d;

  logic                load_en;
  logic                gnt_valid;
  logic [SELSIZE-1:0]  gnt_idx;
  logic [DATASIZE-1:0] gnt_word;

  rr_arbiter #(
    .N  (INSIZE),
    .IW (SELSIZE)
  ) u_arb (
    .req       (in_valid),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load_en = !valid_q || out_ready;

  always_comb begin
    gnt_word = '0;
    in_ready = '0;
    for (int unsigned k = 0; k < INSIZE; k++) begin
      if (SELSIZE'(k) == gnt_idx) gnt_word = in[k*DATASIZE +: DATASIZE];
      in_ready[k] = !rst && load_en && gnt_valid && (SELSIZE'(k) == gnt_idx);
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    src_d   = src_q;
    last_d  = last_q;
    if (load_en) begin
      // An empty load slot clears valid but leaves the last word visible on out.
      valid_d = gnt_valid;
      if (gnt_valid) begin
        out_d  = gnt_word;
        src_d  = gnt_idx;
        last_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      last_q  <= SELSIZE'(INSIZE - 1);
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;

endmodule
